// File: rtl/dac_apb_pkg.sv
// Shared types and constants for the two-DAC APB write scheduler.
package dac_apb_pkg;

    localparam int NUM_CH = 2;

    typedef logic [$clog2(NUM_CH)-1:0] ch_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/dac_rr_arb2.sv
// Two-way round-robin arbiter: the channel not served last wins a tie.
module dac_rr_arb2
    import dac_apb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           last_grant,
    input  logic              update,
    output ch_idx_t           grant,
    output logic              valid
);

    // Channel that wins when both request; channel 0 first after reset.
    ch_idx_t r_prio;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= '0;
        end else if (update) begin
            r_prio <= ~last_grant;
        end
    end

    always_comb begin
        valid = |req;
        if (&req) begin
            grant = r_prio;
        end else if (req[1]) begin
            grant = ch_idx_t'(1);
        end else begin
            grant = ch_idx_t'(0);
        end
    end

endmodule

// File: rtl/dac_apb_sched.sv
// APB write master sharing one bus between two DAC slaves, with round-robin
// grant, per-channel completion counters, slave-error and timeout stickies.
module dac_apb_sched
    import dac_apb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [31:0]       req_data0,
    input  logic [31:0]       req_data1,
    output logic [NUM_CH-1:0] req_ready,
    output logic [NUM_CH-1:0] PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [NUM_CH-1:0] PREADY,
    input  logic [NUM_CH-1:0] PSLVERR,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] slverr_sticky,
    output logic [NUM_CH-1:0] timeout_sticky,
    input  logic [NUM_CH-1:0] err_clr,
    output logic [CNT_W-1:0]  xfer_cnt0,
    output logic [CNT_W-1:0]  xfer_cnt1,
    output logic              busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    ch_idx_t             r_grant;
    logic [NUM_CH-1:0]   r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [31:0]         r_pwdata;
    logic [NUM_CH-1:0]   r_done;
    logic [NUM_CH-1:0]   r_slverr;
    logic [NUM_CH-1:0]   r_timeout;
    logic [CNT_W-1:0]    r_cnt [NUM_CH];
    logic [WAIT_W-1:0]   r_wait;

    ch_idx_t             w_grant;
    logic                w_arb_valid;
    logic                w_ready_g;
    logic                w_expire;
    logic                w_update;
    logic                w_accept;

    // Only the granted slave's handshake inputs are looked at.
    assign w_ready_g = PREADY[r_grant];
    assign w_expire  = !w_ready_g && (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_update  = (r_state == ACCESS) && (w_ready_g || w_expire);
    assign w_accept  = (r_state == IDLE) && w_arb_valid;

    dac_rr_arb2 u_arb (
        .clk        (PCLK),
        .rst        (PRESET),
        .req        (req_valid),
        .last_grant (r_grant),
        .update     (w_update),
        .grant      (w_grant),
        .valid      (w_arb_valid)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_done    <= '0;
            r_slverr  <= '0;
            r_timeout <= '0;
            r_wait    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_done    <= '0;
            // Clears first so a set event later in this block overrides them.
            r_slverr  <= r_slverr & ~err_clr;
            r_timeout <= r_timeout & ~err_clr;
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_grant  <= w_grant;
                        r_pwdata <= w_grant[0] ? req_data1 : req_data0;
                        r_psel   <= ch_onehot(w_grant);
                        r_pwrite <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_ready_g) begin
                        r_done[r_grant] <= 1'b1;
                        r_cnt[r_grant]  <= r_cnt[r_grant] + CNT_W'(1);
                        if (PSLVERR[r_grant]) begin
                            r_slverr[r_grant] <= 1'b1;
                        end
                    end else if (w_expire) begin
                        r_timeout[r_grant] <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                    if (w_update) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_psel    <= '0;
                    r_penable <= 1'b0;
                    r_pwrite  <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = w_accept ? ch_onehot(w_grant) : '0;
    assign PSEL           = r_psel;
    assign PENABLE        = r_penable;
    assign PWRITE         = r_pwrite;
    assign PWDATA         = r_pwdata;
    assign done           = r_done;
    assign slverr_sticky  = r_slverr;
    assign timeout_sticky = r_timeout;
    assign xfer_cnt0      = r_cnt[0];
    assign xfer_cnt1      = r_cnt[1];
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_dac_apb_sched.sv
// Directed bench: a TIMEOUT=16 instance for bus behaviour and a TIMEOUT=4,
// CNT_W=2 instance for abort and counter wrap, both fed by the same stimulus.
module tb_dac_apb_sched;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req_valid, PREADY, PSLVERR, err_clr;
    logic [31:0] req_data0, req_data1;

    logic [1:0]  req_ready, PSEL, done, slverr_sticky, timeout_sticky;
    logic        PENABLE, PWRITE, busy;
    logic [31:0] PWDATA;
    logic [15:0] xfer_cnt0, xfer_cnt1;

    logic [1:0]  t_req_ready, t_psel, t_done, t_slverr, t_timeout;
    logic        t_penable, t_pwrite, t_busy;
    logic [31:0] t_pwdata;
    logic [1:0]  t_cnt0, t_cnt1;

    int checks = 0;
    int failures = 0;

    always #5 PCLK = ~PCLK;

    dac_apb_sched #(.TIMEOUT(16), .CNT_W(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .done(done),
        .slverr_sticky(slverr_sticky), .timeout_sticky(timeout_sticky),
        .err_clr(err_clr), .xfer_cnt0(xfer_cnt0), .xfer_cnt1(xfer_cnt1),
        .busy(busy)
    );

    dac_apb_sched #(.TIMEOUT(4), .CNT_W(2)) dut_t (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(t_req_ready),
        .PSEL(t_psel), .PENABLE(t_penable), .PWRITE(t_pwrite), .PWDATA(t_pwdata),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .done(t_done),
        .slverr_sticky(t_slverr), .timeout_sticky(t_timeout),
        .err_clr(err_clr), .xfer_cnt0(t_cnt0), .xfer_cnt1(t_cnt1),
        .busy(t_busy)
    );

    task automatic step();
        @(posedge PCLK);
        #2;
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #2;
        PRESET = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b00; PREADY = 2'b00; PSLVERR = 2'b00; err_clr = 2'b00;
        req_data0 = '0; req_data1 = '0;
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #2;
        checks++; if (PSEL !== 2'b00 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin failures++; $display("FAIL reset_bus got psel=%b en=%b wr=%b exp 00/0/0", PSEL, PENABLE, PWRITE); end
        checks++; if (PWDATA !== 32'h0 || busy !== 1'b0 || done !== 2'b00) begin failures++; $display("FAIL reset_state got pwdata=%h busy=%b done=%b exp 0/0/00", PWDATA, busy, done); end
        checks++; if (xfer_cnt0 !== 16'd0 || xfer_cnt1 !== 16'd0 || slverr_sticky !== 2'b00 || timeout_sticky !== 2'b00) begin failures++; $display("FAIL reset_status got cnt=%0d/%0d se=%b to=%b exp 0/0/00/00", xfer_cnt0, xfer_cnt1, slverr_sticky, timeout_sticky); end
        PRESET = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_single_write();
        req_valid = 2'b01; req_data0 = 32'h0000_0ABC; PREADY = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        step(); req_valid = 2'b00;
        checks++; if (PSEL !== 2'b01 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || PWDATA !== 32'hABC) begin failures++; $display("FAIL single_setup got psel=%b en=%b wr=%b d=%h exp 01/0/1/abc", PSEL, PENABLE, PWRITE, PWDATA); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL single_ready_drop got=%b exp=00", req_ready); end
        step();
        checks++; if (PSEL !== 2'b01 || PENABLE !== 1'b1 || PWDATA !== 32'hABC) begin failures++; $display("FAIL single_access got psel=%b en=%b d=%h exp 01/1/abc", PSEL, PENABLE, PWDATA); end
        step();
        checks++; if (done !== 2'b01 || xfer_cnt0 !== 16'd1) begin failures++; $display("FAIL single_done got done=%b cnt0=%0d exp 01/1", done, xfer_cnt0); end
        checks++; if (PSEL !== 2'b00 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle got psel=%b en=%b wr=%b busy=%b exp 00/0/0/0", PSEL, PENABLE, PWRITE, busy); end
        step();
        checks++; if (done !== 2'b00) begin failures++; $display("FAIL single_done_pulse got=%b exp=00", done); end
        $display("single write: ch0 data=%h cnt0=%0d", PWDATA, xfer_cnt0);
    endtask

    task automatic test_contention();
        logic [1:0]  exp_oh;
        logic [31:0] exp_d;
        do_reset();
        req_valid = 2'b11; req_data0 = 32'h11; req_data1 = 32'h22; PREADY = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d  = (k % 2 == 0) ? 32'h11 : 32'h22;
            #1;
            checks++; if (req_ready !== exp_oh) begin failures++; $display("FAIL cont_ready k=%0d got=%b exp=%b", k, req_ready, exp_oh); end
            step();
            checks++; if (PSEL !== exp_oh || PWDATA !== exp_d) begin failures++; $display("FAIL cont_setup k=%0d got psel=%b d=%h exp %b/%h", k, PSEL, PWDATA, exp_oh, exp_d); end
            step();
            step();
            checks++; if (done !== exp_oh) begin failures++; $display("FAIL cont_done k=%0d got=%b exp=%b", k, done, exp_oh); end
            $display("contention: xfer %0d grant=%b data=%h", k, exp_oh, exp_d);
        end
        req_valid = 2'b00;
        checks++; if (xfer_cnt0 !== 16'd2 || xfer_cnt1 !== 16'd2) begin failures++; $display("FAIL cont_counts got %0d/%0d exp 2/2", xfer_cnt0, xfer_cnt1); end
    endtask

    task automatic test_wait_states();
        req_valid = 2'b10; req_data1 = 32'hDEAD_BEEF; PREADY = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL wait_ready got=%b exp=10", req_ready); end
        step(); req_valid = 2'b00;
        step();
        for (int i = 0; i < 6; i++) begin
            checks++; if (PSEL !== 2'b10 || PENABLE !== 1'b1 || PWDATA !== 32'hDEAD_BEEF || done !== 2'b00) begin failures++; $display("FAIL wait_hold i=%0d got psel=%b en=%b d=%h done=%b exp 10/1/deadbeef/00", i, PSEL, PENABLE, PWDATA, done); end
            if (i == 5) PREADY = 2'b11;
            step();
        end
        checks++; if (done !== 2'b10 || xfer_cnt1 !== 16'd3 || busy !== 1'b0) begin failures++; $display("FAIL wait_done got done=%b cnt1=%0d busy=%b exp 10/3/0", done, xfer_cnt1, busy); end
        $display("wait states: ch1 completed after 6 access cycles");
    endtask

    task automatic test_slverr();
        req_valid = 2'b01; req_data0 = 32'h5A5A; PREADY = 2'b11; PSLVERR = 2'b01;
        step(); req_valid = 2'b00;
        step(); step();
        checks++; if (done !== 2'b01 || slverr_sticky !== 2'b01) begin failures++; $display("FAIL slverr_set got done=%b se=%b exp 01/01", done, slverr_sticky); end
        err_clr = 2'b01;
        step(); err_clr = 2'b00;
        checks++; if (slverr_sticky !== 2'b00) begin failures++; $display("FAIL slverr_clr got=%b exp=00", slverr_sticky); end
        req_valid = 2'b01; err_clr = 2'b01;
        step(); req_valid = 2'b00;
        step(); step();
        err_clr = 2'b00; PSLVERR = 2'b00;
        checks++; if (slverr_sticky !== 2'b01) begin failures++; $display("FAIL slverr_set_wins got=%b exp=01", slverr_sticky); end
        $display("slave error: sticky=%b", slverr_sticky);
    endtask

    task automatic test_timeout();
        do_reset();
        req_valid = 2'b01; req_data0 = 32'h77; PREADY = 2'b00;
        step(); req_valid = 2'b00;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (t_penable !== 1'b1 || t_psel !== 2'b01 || t_done !== 2'b00) begin failures++; $display("FAIL to_access i=%0d got en=%b psel=%b done=%b exp 1/01/00", i, t_penable, t_psel, t_done); end
            step();
        end
        checks++; if (t_busy !== 1'b0 || t_psel !== 2'b00 || t_penable !== 1'b0) begin failures++; $display("FAIL to_abort got busy=%b psel=%b en=%b exp 0/00/0", t_busy, t_psel, t_penable); end
        checks++; if (t_timeout !== 2'b01 || t_done !== 2'b00 || t_cnt0 !== 2'd0) begin failures++; $display("FAIL to_status got to=%b done=%b cnt0=%0d exp 01/00/0", t_timeout, t_done, t_cnt0); end
        req_valid = 2'b11; PREADY = 2'b11;
        #1;
        checks++; if (t_req_ready !== 2'b10) begin failures++; $display("FAIL to_next_grant got=%b exp=10", t_req_ready); end
        step(); req_valid = 2'b00;
        step(); step();
        checks++; if (t_done !== 2'b10 || t_timeout !== 2'b01) begin failures++; $display("FAIL to_next_done got done=%b to=%b exp 10/01", t_done, t_timeout); end
        $display("timeout: ch0 aborted, ch1 served next");
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_c;
        do_reset();
        req_valid = 2'b01; PREADY = 2'b11; req_data0 = 32'h3;
        for (int k = 0; k < 4; k++) begin
            step(); step(); step();
            exp_c = 2'((k + 1) % 4);
            checks++; if (t_cnt0 !== exp_c || t_done !== 2'b01) begin failures++; $display("FAIL wrap k=%0d got cnt0=%0d done=%b exp %0d/01", k, t_cnt0, t_done, exp_c); end
            $display("wrap: xfer %0d cnt0=%0d", k, t_cnt0);
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_reset_mid_access();
        checks++; if (xfer_cnt0 !== 16'd4) begin failures++; $display("FAIL pre_reset_cnt got=%0d exp=4", xfer_cnt0); end
        req_valid = 2'b01; PREADY = 2'b00;
        step(); req_valid = 2'b00;
        step();
        checks++; if (busy !== 1'b1 || PENABLE !== 1'b1) begin failures++; $display("FAIL rst_in_access got busy=%b en=%b exp 1/1", busy, PENABLE); end
        PRESET = 1'b1;
        #1;
        checks++; if (PSEL !== 2'b00 || PENABLE !== 1'b0 || busy !== 1'b0 || PWRITE !== 1'b0) begin failures++; $display("FAIL rst_async got psel=%b en=%b busy=%b wr=%b exp 00/0/0/0", PSEL, PENABLE, busy, PWRITE); end
        checks++; if (xfer_cnt0 !== 16'd0 || slverr_sticky !== 2'b00 || timeout_sticky !== 2'b00 || done !== 2'b00) begin failures++; $display("FAIL rst_status got cnt0=%0d se=%b to=%b done=%b exp 0/00/00/00", xfer_cnt0, slverr_sticky, timeout_sticky, done); end
        PRESET = 1'b0; PREADY = 2'b11;
        step();
        checks++; if (done !== 2'b00) begin failures++; $display("FAIL rst_no_done got=%b exp=00", done); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_prio got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        $display("reset mid-access: bus dropped, ch0 priority restored");
    endtask

    initial begin
        PRESET = 1'b1;
        test_reset();
        test_single_write();
        test_contention();
        test_wait_states();
        test_slverr();
        test_timeout();
        test_counter_wrap();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
